// File: rtl/serial_cmd_pkg.sv
// Shared types for the serial command controller and the MAC/accumulator datapath.
package serial_cmd_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_OP,
    ST_STOP,
    ST_EXEC,
    ST_SKIP
  } state_t;

  // Opcode names understood by the datapath (3-bit opcode field)
  typedef enum logic [2:0] {
    OUT_DATA1 = 3'd0,
    OUT_DATA2 = 3'd1,
    LOAD_A    = 3'd2,
    LOAD_B    = 3'd3,
    CLEAR_ACC = 3'd4,
    MUL       = 3'd5,
    MUL_ADD   = 3'd6,
    OP_NOP    = 3'd7
  } op_name_t;

  // Largest of three integers, used for counter sizing
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/serial_bit_sampler.sv
// Two-flop synchroniser for rx plus a bit-period counter that strobes at mid-bit.
// While hunt is high the counter waits preloaded for the half-bit to the start-bit centre.
module serial_bit_sampler #(
  parameter int BIT_PERIOD = 4
) (
  input  logic clk,
  input  logic nRst,
  input  logic rx,
  input  logic hunt,
  output logic rx_s,
  output logic strobe
);

  localparam int CNT_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'((BIT_PERIOD / 2 > 0) ? BIT_PERIOD / 2 - 1 : 0);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_PERIOD - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic [CNT_W-1:0] cnt_reg;

  assign rx_s   = sync2_reg;
  assign strobe = !hunt && (cnt_reg == '0);

  // Synchronise rx into the clk domain; flops rest at the idle line level
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= rx;
      sync2_reg <= sync1_reg;
    end
  end

  // Mid-bit counter: half period to the start-bit centre, then full periods
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt_reg <= HALF_LOAD;
    end else if (hunt) begin
      cnt_reg <= HALF_LOAD;
    end else if (cnt_reg == '0) begin
      cnt_reg <= FULL_LOAD;
    end else begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

endmodule

// File: rtl/serial_cmd_ctrl.sv
// Serial command controller: receives address+opcode frames, filters on own/broadcast
// address, checks the stop bit and presents the opcode for a per-opcode execute window.
module serial_cmd_ctrl
  import serial_cmd_pkg::*;
#(
  parameter int                      ADDR_W       = 8,
  parameter int                      OP_W         = 3,
  parameter int                      BIT_PERIOD   = 4,
  parameter logic [OP_W-1:0]         NOP          = OP_W'((1 << OP_W) - 1),
  parameter logic [(1<<OP_W)-1:0]    PULSE_MASK   = 8'h60,
  parameter logic [(1<<OP_W)-1:0]    LONG_MASK    = 8'h0C,
  parameter int                      LONG_CYCLES  = 128,
  parameter int                      SHORT_CYCLES = 32,
  parameter int                      GUARD        = 8
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic [ADDR_W-1:0] address,
  input  logic              rx,
  output logic [OP_W-1:0]   opcode,
  output logic              op_valid,
  output logic              busy,
  output logic              frame_err
);

  // Skip time after a foreign-address frame: rest of the frame plus the guard gap
  localparam int SKIP_CYCLES = (OP_W + 1) * BIT_PERIOD + GUARD;
  localparam int WCNT_W      = $clog2(max3(LONG_CYCLES, SHORT_CYCLES, SKIP_CYCLES) + 1);
  localparam int BIDX_W      = $clog2(max3(ADDR_W, OP_W, 1) + 1);

  // Counters hold "cycles remaining minus one" so each state lasts exactly N cycles
  localparam logic [WCNT_W-1:0] LONG_LOAD  = WCNT_W'(LONG_CYCLES - 1);
  localparam logic [WCNT_W-1:0] SHORT_LOAD = WCNT_W'(SHORT_CYCLES - 1);
  localparam logic [WCNT_W-1:0] SKIP_LOAD  = WCNT_W'(SKIP_CYCLES - 1);
  localparam logic [WCNT_W-1:0] GUARD_LOAD = WCNT_W'((GUARD > 0) ? GUARD - 1 : 0);

  state_t              state_reg;
  logic [OP_W-1:0]     opcode_reg;
  logic                op_valid_reg;
  logic                busy_reg;
  logic                frame_err_reg;
  logic [ADDR_W-1:0]   addr_sh_reg;
  logic [OP_W-1:0]     op_sh_reg;
  logic [BIDX_W-1:0]   bit_idx_reg;
  logic [WCNT_W-1:0]   wcnt_reg;

  logic                rx_s;
  logic                strobe;
  logic                hunt;
  logic [ADDR_W-1:0]   addr_next;
  logic [OP_W-1:0]     op_next;
  logic                addr_match;

  assign opcode    = opcode_reg;
  assign op_valid  = op_valid_reg;
  assign busy      = busy_reg;
  assign frame_err = frame_err_reg;

  // The sampler only counts bit periods while a frame is being received
  assign hunt = !(state_reg inside {ST_START, ST_ADDR, ST_OP, ST_STOP});

  // LSB-first shift: the new bit enters at the top
  assign addr_next  = ADDR_W'({rx_s, addr_sh_reg} >> 1);
  assign op_next    = OP_W'({rx_s, op_sh_reg} >> 1);
  assign addr_match = (addr_next == address) || (addr_next == '1);

  serial_bit_sampler #(
    .BIT_PERIOD(BIT_PERIOD)
  ) u_sampler (
    .clk   (clk),
    .nRst  (nRst),
    .rx    (rx),
    .hunt  (hunt),
    .rx_s  (rx_s),
    .strobe(strobe)
  );

  // Frame FSM with shift registers, window counter and registered outputs
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_reg     <= ST_IDLE;
      opcode_reg    <= NOP;
      op_valid_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
      addr_sh_reg   <= '1;
      op_sh_reg     <= '1;
      bit_idx_reg   <= '0;
      wcnt_reg      <= '0;
    end else begin
      op_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (!rx_s) begin
            busy_reg    <= 1'b1;
            bit_idx_reg <= '0;
            // With one clk per bit the detecting sample already is the start-bit centre
            state_reg   <= (BIT_PERIOD / 2 == 0) ? ST_ADDR : ST_START;
          end
        end
        ST_START: begin
          if (strobe) begin
            if (rx_s) begin
              state_reg <= ST_IDLE;   // too short to be a start bit
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (strobe) begin
            addr_sh_reg <= addr_next;
            if (bit_idx_reg == BIDX_W'(ADDR_W - 1)) begin
              bit_idx_reg <= '0;
              if (addr_match) begin
                state_reg <= ST_OP;
              end else begin
                state_reg <= ST_SKIP;
                wcnt_reg  <= SKIP_LOAD;
              end
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end
        end
        ST_OP: begin
          if (strobe) begin
            op_sh_reg <= op_next;
            if (bit_idx_reg == BIDX_W'(OP_W - 1)) begin
              bit_idx_reg <= '0;
              state_reg   <= ST_STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (strobe) begin
            if (rx_s) begin
              opcode_reg   <= op_sh_reg;
              op_valid_reg <= 1'b1;
              wcnt_reg     <= ((op_sh_reg != NOP) && LONG_MASK[op_sh_reg]) ? LONG_LOAD : SHORT_LOAD;
              state_reg    <= ST_EXEC;
            end else begin
              frame_err_reg <= 1'b1;
              wcnt_reg      <= GUARD_LOAD;
              state_reg     <= ST_SKIP;
            end
          end
        end
        ST_EXEC: begin
          if (wcnt_reg == '0) begin
            opcode_reg <= NOP;
            state_reg  <= ST_IDLE;
            busy_reg   <= 1'b0;
          end else begin
            wcnt_reg <= wcnt_reg - 1'b1;
            // Pulse opcodes are shown for their first cycle only; the window still runs
            if (op_valid_reg && PULSE_MASK[opcode_reg]) begin
              opcode_reg <= NOP;
            end
          end
        end
        ST_SKIP: begin
          if (wcnt_reg != '0) begin
            wcnt_reg <= wcnt_reg - 1'b1;
          end else if (rx_s) begin
            // A line stuck low is held here instead of being taken as a new start bit
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg  <= ST_IDLE;
          opcode_reg <= NOP;
          busy_reg   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cmd_ctrl.sv
// Testbench for serial_cmd_ctrl: directed frames with literal expectations plus randomized
// frames, all checked every cycle against a timeline model built from frame timing rules.
module tb_serial_cmd_ctrl;
  import serial_cmd_pkg::*;

  localparam int A      = 8;
  localparam int O      = 3;
  localparam int BP     = 4;
  localparam int H      = BP / 2;
  localparam int LONGC  = 128;
  localparam int SHORTC = 32;
  localparam int GRD    = 8;
  localparam int SKIPC  = (O + 1) * BP + GRD;
  localparam int MAXC   = 24000;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] address = 8'h3A;
  logic [2:0] opcode;
  logic       op_valid;
  logic       busy;
  logic       frame_err;

  logic [7:0] pulse_ops = 8'h60;
  logic [7:0] long_ops  = 8'h0C;
  logic [2:0] nopv      = 3'd7;

  serial_cmd_ctrl dut (
    .clk      (clk),
    .nRst     (nRst),
    .address  (address),
    .rx       (rx),
    .opcode   (opcode),
    .op_valid (op_valid),
    .busy     (busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; outputs seen at a falling edge belong to edge pcount
  int pcount = 0;
  always @(posedge clk) pcount <= pcount + 1;

  // Expected output timeline, indexed by rising-edge number
  bit       exp_busy  [MAXC];
  bit       exp_valid [MAXC];
  bit       exp_ferr  [MAXC];
  logic [2:0] exp_op  [MAXC];

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0d, expected %0d", name, pcount, act, exp);
  endtask

  // Per-cycle comparison against the model timeline
  always @(negedge clk) begin
    if (chk_en && pcount < MAXC) begin
      check("busy", int'(busy), int'(exp_busy[pcount]));
      check("op_valid", int'(op_valid), int'(exp_valid[pcount]));
      check("frame_err", int'(frame_err), int'(exp_ferr[pcount]));
      check("opcode", int'(opcode), int'(exp_op[pcount]));
    end
  end

  // Measurement counters for the directed literal checks
  int         m_busy, m_valid, m_ferr, m_opcnt, m_first_valid;
  logic [2:0] m_op = 3'd0;
  always @(negedge clk) begin
    if (busy) m_busy++;
    if (op_valid) begin
      m_valid++;
      if (m_first_valid < 0) m_first_valid = pcount;
    end
    if (frame_err) m_ferr++;
    if (opcode == m_op) m_opcnt++;
  end

  task automatic clear_meas(input logic [2:0] op);
    m_busy = 0; m_valid = 0; m_ferr = 0; m_opcnt = 0; m_first_valid = -1; m_op = op;
  endtask

  // Model: given the edge s where the start bit is first sampled, derive every output event
  task automatic model_frame(input int s, input logic [7:0] a, input logic [2:0] op,
                             input bit stopb, output int e);
    int ta, ts, n;
    ta = s + 2 + H + BP * A;            // edge of the last address-bit sample
    if (!(a == address || a == 8'hFF)) begin
      e = ta + SKIPC;
    end else begin
      ts = ta + BP * (O + 1);           // edge of the stop-bit sample
      if (!stopb) begin
        e = ts + GRD;
        if (ts < MAXC) exp_ferr[ts] = 1'b1;
      end else begin
        n = (long_ops[op] && op != nopv) ? LONGC : SHORTC;
        e = ts + n;
        if (ts < MAXC) exp_valid[ts] = 1'b1;
        for (int p = ts; p < e && p < MAXC; p++)
          exp_op[p] = (pulse_ops[op] && p > ts) ? nopv : op;
      end
    end
    for (int p = s + 2; p < e && p < MAXC; p++) exp_busy[p] = 1'b1;
  endtask

  task automatic model_reset(input int from, input int upto);
    for (int p = from; p < upto && p < MAXC; p++) begin
      exp_busy[p] = 1'b0; exp_valid[p] = 1'b0; exp_ferr[p] = 1'b0; exp_op[p] = nopv;
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BP) @(negedge clk);
  endtask

  // Called at a falling edge; returns the edge at which the DUT must be idle again
  task automatic start_frame(input logic [7:0] a, input logic [2:0] op, input bit stopb,
                             output int s, output int e);
    s = pcount + 1;
    model_frame(s, a, op, stopb, e);
    drive_bit(1'b0);
    for (int i = 0; i < A; i++) drive_bit(a[i]);
    for (int i = 0; i < O; i++) drive_bit(op[i]);
    drive_bit(stopb);
    rx = 1'b1;
  endtask

  task automatic glitch(output int s, output int e);
    s = pcount + 1;
    e = s + 2 + H;
    for (int p = s + 2; p < e && p < MAXC; p++) exp_busy[p] = 1'b1;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_until(input int p);
    int guard;
    guard = 0;
    while (pcount < p && guard < MAXC) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #(MAXC * 10);
    $display("FAIL watchdog: simulation exceeded %0d cycles", MAXC);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, e, q;
    for (int p = 0; p < MAXC; p++) exp_op[p] = nopv;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_opcode", int'(opcode), 7);
    check("rst_busy", int'(busy), 0);
    check("rst_op_valid", int'(op_valid), 0);
    check("rst_frame_err", int'(frame_err), 0);
    #2 nRst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    // 1: own address, MUL (pulse, short window)
    clear_meas(MUL);
    start_frame(8'h3A, MUL, 1'b1, s, e);
    wait_until(e);
    check("t1_latency", m_first_valid - s, 52);
    check("t1_valid_cnt", m_valid, 1);
    check("t1_op_cycles", m_opcnt, 1);
    check("t1_busy_cycles", m_busy, 82);       // 50 receive + 32 window
    $display("t1 addr=3A op=5 busy=%0d", m_busy);

    // 2: own address, LOAD_A (long window)
    clear_meas(LOAD_A);
    start_frame(8'h3A, LOAD_A, 1'b1, s, e);
    wait_until(e);
    check("t2_op_cycles", m_opcnt, 128);
    check("t2_busy_cycles", m_busy, 178);
    check("t2_after_op", int'(opcode), 7);
    $display("t2 addr=3A op=2 op_cycles=%0d", m_opcnt);

    // 3: broadcast accepted, foreign address skipped
    clear_meas(CLEAR_ACC);
    start_frame(8'hFF, CLEAR_ACC, 1'b1, s, e);
    wait_until(e);
    check("t3_bcast_valid", m_valid, 1);
    check("t3_bcast_op_cycles", m_opcnt, 32);
    $display("t3 addr=FF op=4 valid=%0d", m_valid);
    clear_meas(MUL_ADD);
    start_frame(8'h3B, MUL_ADD, 1'b1, s, e);
    wait_until(e);
    check("t3_skip_valid", m_valid, 0);
    check("t3_skip_busy", m_busy, 58);         // 34 receive + 24 skip
    $display("t3 addr=3B op=6 busy=%0d", m_busy);

    // 4: bad stop bit
    clear_meas(OUT_DATA2);
    start_frame(8'h3A, OUT_DATA2, 1'b0, s, e);
    wait_until(e);
    check("t4_ferr_cnt", m_ferr, 1);
    check("t4_valid", m_valid, 0);
    check("t4_op_cycles", m_opcnt, 0);
    check("t4_busy_cycles", m_busy, 58);       // 50 receive + 8 guard
    $display("t4 addr=3A op=1 stop=0 ferr=%0d", m_ferr);

    // 5: single-cycle glitch
    clear_meas(MUL);
    glitch(s, e);
    wait_until(e);
    check("t5_busy_cycles", m_busy, 2);
    check("t5_valid", m_valid, 0);
    $display("t5 glitch busy=%0d", m_busy);

    // 6: reset during EXEC, then a good frame
    start_frame(8'h3A, LOAD_B, 1'b1, s, e);
    repeat (20) @(negedge clk);
    q = pcount;
    model_reset(q + 1, e);
    #2 nRst = 1'b0;
    #1;
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_opcode", int'(opcode), 7);
    repeat (3) @(negedge clk);
    #2 nRst = 1'b1;
    @(negedge clk);
    clear_meas(OUT_DATA1);
    start_frame(8'h3A, OUT_DATA1, 1'b1, s, e);
    wait_until(e);
    check("t6_next_valid", m_valid, 1);
    check("t6_next_op_cycles", m_opcnt, 32);
    $display("t6 reset in exec, next op=0 valid=%0d", m_valid);

    // Randomized frames
    for (int k = 0; k < 40; k++) begin
      int         kind, r;
      logic [7:0] a;
      logic [2:0] op;
      bit         sb;
      if (k % 10 == 9) address = 8'($urandom_range(0, 254));
      kind = $urandom_range(0, 99);
      if (kind < 10) begin
        glitch(s, e);
        $display("rnd %0d glitch", k);
      end else begin
        r = $urandom_range(0, 9);
        if (r < 5) a = address;
        else if (r < 7) a = 8'hFF;
        else begin
          a = 8'($urandom_range(0, 255));
          while (a == address || a == 8'hFF) a = a + 8'd1;
        end
        op = 3'($urandom_range(0, 7));
        sb = ($urandom_range(0, 99) >= 15);
        start_frame(a, op, sb, s, e);
        $display("rnd %0d addr=%02h node=%02h op=%0d stop=%0d", k, a, address, op, sb);
      end
      wait_until(e);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
